i2s_tx_serializer: RTL and testbench
====================================

// Module: i2s_tx_serializer
// PURPOSE
//  Output end of the equalizer audio path. Accepts 24-bit signed samples from the
//  equalizer's audio_out over a valid/ready handshake and serializes them onto an
//  I2S (Philips) link as bclk/lrclk/sdata for the DAC.
//  Mono source: each sample is sent in both the left and right slots of one frame.
//  A one-entry holding buffer decouples the sample producer from the frame timing.
// PARAMETERS
//  DATA_W    24  sample width in bits, MSB first in each slot
//  SLOT_W    32  bclk periods per channel slot; must be >= DATA_W
//  BCLK_DIV  4   clk cycles per bclk period; must be even and >= 2
// PORTS
//  clk           in   1       system clock
//  rst_n         in   1       asynchronous active-low reset
//  en            in   1       serializer enable, sampled at frame boundary
//  sample_in     in   DATA_W  signed sample from the equalizer
//  sample_valid  in   1       sample_in is valid
//  sample_ready  out  1       holding buffer empty; sample is accepted when valid & ready
//  bclk          out  1       I2S bit clock
//  lrclk         out  1       I2S word select: 0 = left, 1 = right
//  sdata         out  1       I2S serial data
//  underrun      out  1       one-clk pulse when a frame starts with the buffer empty
// BEHAVIOUR
//  Reset (async): bclk=0, lrclk=0, sdata=0, underrun=0, buffer empty (sample_ready=1),
//   last-sample register=0, div_cnt=0, pos=0, state=IDLE.
//  Handshake: sample_ready = ~buf_full. A transfer occurs on a clk edge with valid&ready.
//   The buffer accepts samples in IDLE too. valid held with ready low -> sample held, no loss.
//  FSM: IDLE -> RUN when en=1 (checked every clk in IDLE). RUN -> IDLE only at the end of
//   a frame (pos=2*SLOT_W-1 falling edge) with en=0. A mid-frame deassert of en finishes
//   the frame. In IDLE, bclk/lrclk/sdata are forced to 0, and div_cnt and pos are held at 0.
//  Bit clock (RUN): div_cnt counts 0..BCLK_DIV-1 and wraps. bclk=1 while div_cnt>=BCLK_DIV/2.
//   Falling-edge event = the clk edge where div_cnt wraps to 0. pos (0..2*SLOT_W-1)
//   advances on each falling-edge event and wraps to 0.
//  Frame start (entry to RUN, or pos wraps to 0):
//   - Buffer full: shift word <= buffer, last <= buffer, buffer emptied on the same edge.
//   - Buffer empty: shift word <= last, underrun pulses for 1 clk.
//   - A valid&ready on the same edge as the load writes the buffer. No conflict, because
//     ready was already 1.
//  Output timing, all registered and updated on falling-edge events:
//   - For position p, i = p mod SLOT_W.
//   - sdata = (i < DATA_W) ? word[DATA_W-1-i] : 0.
//   - lrclk = 1 for p in [SLOT_W-1, 2*SLOT_W-2], else 0. lrclk therefore changes one bclk
//     before the MSB of each slot.
//  Latency: a sample accepted during frame N is transmitted in frame N+1. Throughput is one
//   sample per 2*SLOT_W*BCLK_DIV clk.
//  Arithmetic: no scaling or rounding. Bits are passed through in two's complement.
//   Pad bits are 0.
// TESTING
//  1 Reset mid-frame: assert rst_n=0 -> all outputs 0 on the same edge; sample_ready=1;
//    with en=1 after release, the first frame sends 0x000000 and pulses underrun.
//  2 DATA_W=24, SLOT_W=32, BCLK_DIV=4; send 0xA5A5A5, then en=1 -> bclk period 4 clk;
//    frame = 256 clk; both slots decode to 0xA5A5A5; bits 24..31 of each slot are 0.
//  3 Lrclk alignment: check that lrclk rises on the falling-edge event before right-slot
//    MSB (p=31) and falls at p=63; the MSB appears one bclk after each lrclk edge.
//  4 Backpressure: hold valid with 0x123456 then 0x7FFFFF back-to-back -> second waits for
//    ready; frames carry 0x123456 then 0x7FFFFF; no sample is dropped or duplicated.
//  5 Underrun: stop supplying after 0x800000 -> next frame repeats 0x800000 in both slots;
//    underrun is exactly one clk high at that frame start; no pulse when the buffer was full.
//  6 Disable: drop en at p=10 -> frame completes to p=63, then bclk/lrclk/sdata stay 0;
//    re-enable -> the new frame starts with pos=0, lrclk=0.

Source files
------------

// File: rtl/i2s_tx_serializer.sv
// I2S (Philips) transmitter for a mono 24-bit stream: every accepted sample is sent in
// both the left and right slot of one frame, through a one-entry holding buffer.
module i2s_tx_serializer #(
  parameter int DATA_W   = 24,
  parameter int SLOT_W   = 32,
  parameter int BCLK_DIV = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [DATA_W-1:0] sample_in,
  input  logic              sample_valid,
  output logic              sample_ready,
  output logic              bclk,
  output logic              lrclk,
  output logic              sdata,
  output logic              underrun,
  output logic              dbg_state
);

  localparam int POS_W = $clog2(2 * SLOT_W);
  localparam int DIV_W = $clog2(BCLK_DIV);
  localparam logic [POS_W-1:0] LAST_POS = POS_W'(2 * SLOT_W - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(BCLK_DIV / 2);

  typedef enum logic {IDLE, RUN} state_t;

  state_t              state_q, state_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [POS_W-1:0]    pos_q, pos_d;
  logic [DATA_W-1:0]   buf_q, buf_d;
  logic                buf_full_q, buf_full_d;
  logic [DATA_W-1:0]   last_q, last_d;
  logic [DATA_W-1:0]   word_q, word_d;
  logic [DATA_W-1:0]   sh_q, sh_d;
  logic                bclk_q, bclk_d;
  logic                lrclk_q, lrclk_d;
  logic                sdata_q, sdata_d;
  logic                underrun_q, underrun_d;

  logic                fall;
  logic                frame_start;
  logic                accept;
  logic [DATA_W-1:0]   load_word;
  logic [POS_W-1:0]    slot_idx;

  // Handshake: sample_ready is high exactly when the holding buffer is empty; a sample
  // transfers on any clk edge with sample_valid & sample_ready, in IDLE as well as RUN.
  assign accept = sample_valid && !buf_full_q;

  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    pos_d       = pos_q;
    buf_d       = buf_q;
    buf_full_d  = buf_full_q;
    last_d      = last_q;
    word_d      = word_q;
    sh_d        = sh_q;
    bclk_d      = 1'b0;
    lrclk_d     = lrclk_q;
    sdata_d     = sdata_q;
    underrun_d  = 1'b0;
    frame_start = 1'b0;
    fall        = (state_q == RUN) && (div_q == DIV_LAST);
    load_word   = buf_full_q ? buf_q : last_q;
    slot_idx    = '0;

    case (state_q)
      IDLE: begin
        div_d = '0;
        pos_d = '0;
        if (en) begin
          state_d     = RUN;
          frame_start = 1'b1;
        end
      end
      RUN: begin
        if (fall) begin
          div_d = '0;
          if (pos_q == LAST_POS) begin
            pos_d = '0;
            // en only matters at the frame boundary; a mid-frame drop finishes the frame.
            if (en) frame_start = 1'b1;
            else    state_d     = IDLE;
          end else begin
            pos_d = pos_q + POS_W'(1);
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (frame_start) begin
      word_d     = load_word;
      last_d     = load_word;
      sh_d       = load_word;
      underrun_d = !buf_full_q;
      if (buf_full_q) buf_full_d = 1'b0;
    end else if (fall) begin
      // The right slot restarts from the same word; otherwise move to the next bit.
      sh_d = (pos_d == POS_W'(SLOT_W)) ? word_q : (sh_q << 1);
    end

    if (accept) begin
      buf_d      = sample_in;
      buf_full_d = 1'b1;
    end

    slot_idx = (pos_d >= POS_W'(SLOT_W)) ? (pos_d - POS_W'(SLOT_W)) : pos_d;

    if (state_d == IDLE) begin
      lrclk_d = 1'b0;
      sdata_d = 1'b0;
    end else begin
      bclk_d = (div_d >= DIV_HALF);
      if (frame_start || fall) begin
        // lrclk leads each slot by one bclk, as I2S requires.
        lrclk_d = (pos_d >= POS_W'(SLOT_W - 1)) && (pos_d <= POS_W'(2 * SLOT_W - 2));
        sdata_d = (slot_idx < POS_W'(DATA_W)) ? sh_d[DATA_W-1] : 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      div_q      <= '0;
      pos_q      <= '0;
      buf_q      <= '0;
      buf_full_q <= 1'b0;
      last_q     <= '0;
      word_q     <= '0;
      sh_q       <= '0;
      bclk_q     <= 1'b0;
      lrclk_q    <= 1'b0;
      sdata_q    <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      pos_q      <= pos_d;
      buf_q      <= buf_d;
      buf_full_q <= buf_full_d;
      last_q     <= last_d;
      word_q     <= word_d;
      sh_q       <= sh_d;
      bclk_q     <= bclk_d;
      lrclk_q    <= lrclk_d;
      sdata_q    <= sdata_d;
      underrun_q <= underrun_d;
    end
  end

  assign sample_ready = !buf_full_q;
  assign bclk         = bclk_q;
  assign lrclk        = lrclk_q;
  assign sdata        = sdata_q;
  assign underrun     = underrun_q;
  assign dbg_state    = (state_q == RUN);

endmodule

// File: tb/tb_i2s_tx_serializer.sv
// Bench for i2s_tx_serializer: frame-time reference model checked every clk, plus an
// I2S receiver that decodes the link and compares each slot against an expected queue.
module tb_i2s_tx_serializer;

  localparam int DATA_W    = 24;
  localparam int SLOT_W    = 32;
  localparam int BCLK_DIV  = 4;
  localparam int FRAME_CLK = 2 * SLOT_W * BCLK_DIV;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  logic en;
  logic [DATA_W-1:0] sample_in;
  logic sample_valid;
  logic sample_ready, bclk, lrclk, sdata, underrun, dbg_state;

  always #5 clk = ~clk;

  i2s_tx_serializer #(.DATA_W(DATA_W), .SLOT_W(SLOT_W), .BCLK_DIV(BCLK_DIV)) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .sample_in(sample_in), .sample_valid(sample_valid), .sample_ready(sample_ready),
    .bclk(bclk), .lrclk(lrclk), .sdata(sdata), .underrun(underrun),
    .dbg_state(dbg_state)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // ---------------- reference model state ----------------
  bit                m_run;
  int                m_t;       // clk count since the frame started
  logic [DATA_W-1:0] m_word, m_last, m_buf;
  bit                m_full, m_und;

  logic [DATA_W-1:0] src_q[$];  // samples the producer still has to hand over
  logic [DATA_W-1:0] exp_q[$];  // slot words the receiver must decode, in order
  bit                hold_v;
  bit                gap_en;

  // ---------------- receiver state ----------------
  bit                rx_idle;
  int                rx_cnt;
  int                idle_cnt;
  logic              rx_lr_prev;
  logic              bclk_prev;
  logic [DATA_W-1:0] rx_w;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
  endtask

  task automatic model_reset();
    m_run = 0; m_t = 0; m_word = '0; m_last = '0; m_buf = '0; m_full = 0; m_und = 0;
    exp_q.delete();
    rx_idle = 1; rx_cnt = 0; idle_cnt = 0; rx_lr_prev = 1'b0; bclk_prev = 1'b0; rx_w = '0;
    hold_v = 0;
  endtask

  task automatic model_step(input bit e, input bit v, input logic [DATA_W-1:0] d,
                            output bit acc);
    bit fs;
    fs    = 0;
    acc   = v && !m_full;
    m_und = 0;
    if (!m_run) begin
      if (e) begin m_run = 1; m_t = 0; fs = 1; end
    end else if (m_t == FRAME_CLK - 1) begin
      m_t = 0;
      if (e) fs = 1; else m_run = 0;
    end else begin
      m_t++;
    end
    if (fs) begin
      if (m_full) begin m_word = m_buf; m_last = m_buf; m_full = 0; end
      else begin m_word = m_last; m_und = 1; end
      exp_q.push_back(m_word);
      exp_q.push_back(m_word);
    end
    if (acc) begin m_full = 1; m_buf = d; end
  endtask

  task automatic check_outputs();
    logic e_bclk, e_lr, e_sd;
    logic [DATA_W-1:0] tmp;
    int ph, p, i;
    e_bclk = 0; e_lr = 0; e_sd = 0;
    if (m_run) begin
      ph = m_t % BCLK_DIV;
      p  = m_t / BCLK_DIV;
      i  = p % SLOT_W;
      e_bclk = (ph >= BCLK_DIV / 2);
      e_lr   = (p >= SLOT_W - 1) && (p <= 2 * SLOT_W - 2);
      if (i < DATA_W) begin
        tmp  = m_word >> (DATA_W - 1 - i);
        e_sd = tmp[0];
      end
    end
    check("bclk", bclk, e_bclk);
    check("lrclk", lrclk, e_lr);
    check("sdata", sdata, e_sd);
    check("underrun", underrun, m_und);
    check("sample_ready", sample_ready, !m_full);
    check("state", dbg_state, m_run);

    // Receiver: samples sdata on bclk rising edges, word boundaries from lrclk alone.
    if (bclk === 1'b0) begin
      idle_cnt++;
      if (idle_cnt > BCLK_DIV) rx_idle = 1;
    end else begin
      idle_cnt = 0;
    end
    if (bclk === 1'b1 && bclk_prev === 1'b0) begin
      if (rx_idle) begin
        rx_idle = 0; rx_cnt = 0; rx_lr_prev = lrclk;
      end else if (lrclk !== rx_lr_prev) begin
        rx_lr_prev = lrclk; rx_cnt = -1;
      end
      if (rx_cnt >= 0 && rx_cnt < DATA_W) begin
        rx_w = {rx_w[DATA_W-2:0], sdata};
        rx_cnt++;
        if (rx_cnt == DATA_W) begin
          if (exp_q.size() == 0) check("rx_extra_word", 32'(rx_w), 32'hFFFF_FFFF);
          else check("rx_word", 32'(rx_w), 32'(exp_q.pop_front()));
        end
      end else if (rx_cnt < 0) begin
        rx_cnt = 0;
      end
    end
    bclk_prev = bclk;
  endtask

  // ---------------- driver ----------------
  task automatic tick(input bit e);
    bit v, acc;
    v = hold_v || (src_q.size() > 0 && (!gap_en || $urandom_range(0, 3) != 0));
    en = e;
    sample_valid = v;
    if (v) sample_in = src_q[0];
    else   sample_in = DATA_W'($urandom);
    @(posedge clk);
    acc = 0;
    if (rst_n) model_step(e, v, sample_in, acc);
    if (acc) void'(src_q.pop_front());
    hold_v = v && !acc;
    @(negedge clk);
    check_outputs();
  endtask

  task automatic run(input bit e, input int n);
    for (int k = 0; k < n; k++) tick(e);
  endtask

  task automatic run_until_idle(input int limit);
    int k;
    k = 0;
    while (m_run && k < limit) begin tick(1'b0); k++; end
    if (m_run) check("idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic run_until_pos(input int p, input int limit);
    int k;
    k = 0;
    while (!(m_run && m_t == p * BCLK_DIV) && k < limit) begin tick(1'b1); k++; end
    if (!(m_run && m_t == p * BCLK_DIV)) check("pos_timeout", 32'd1, 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0; en = 1'b0; sample_valid = 1'b0; sample_in = '0; gap_en = 0;
    model_reset();
    @(negedge clk);
    check_outputs();
    rst_n = 1'b1;

    // Reset in the middle of a running frame.
    run(1'b1, 100);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_bclk", bclk, 1'b0);
    check("rst_lrclk", lrclk, 1'b0);
    check("rst_sdata", sdata, 1'b0);
    check("rst_underrun", underrun, 1'b0);
    check("rst_ready", sample_ready, 1'b1);
    @(negedge clk);
    run(1'b1, 3);
    rst_n = 1'b1;
    run(1'b1, FRAME_CLK + 10);   // zero frame with underrun at its start

    // Sample loaded while idle, then enable.
    run_until_idle(2 * FRAME_CLK);
    run(1'b0, 10);
    src_q.push_back(24'hA5A5A5);
    run(1'b0, 4);
    run(1'b1, 2 * FRAME_CLK);

    // Back-to-back samples with valid held under backpressure.
    src_q.push_back(24'h123456);
    src_q.push_back(24'h7FFFFF);
    run(1'b1, 3 * FRAME_CLK);

    // Producer stops: frames repeat the last sample with underrun pulses.
    src_q.push_back(24'h800000);
    run(1'b1, 3 * FRAME_CLK);

    // Random samples with random valid gaps.
    gap_en = 1;
    for (int k = 0; k < 8; k++) src_q.push_back(DATA_W'($urandom));
    for (int k = 0; k < 12 * FRAME_CLK && src_q.size() > 0; k++) tick(1'b1);
    if (src_q.size() != 0) check("src_drain_timeout", 32'(src_q.size()), 32'd0);
    run(1'b1, 2 * FRAME_CLK);
    gap_en = 0;

    // Disable mid-frame at p=10, stay idle, then re-enable.
    run_until_pos(10, 2 * FRAME_CLK);
    run_until_idle(2 * FRAME_CLK);
    run(1'b0, 40);
    src_q.push_back(DATA_W'($urandom));
    run(1'b1, FRAME_CLK + 20);

    run_until_idle(2 * FRAME_CLK);
    run(1'b0, 20);
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
